// File: rtl/tt_um_tpu.sv
// tt_um_tpu: 2x2 matrix multiplier (C = A x B) built from a 2x2 array of
// multiply-accumulate cells. Operands are loaded byte-serially. The 16-bit
// results are read back byte-serially, high byte first.
// Optional macro TPU_SIGNED_EN: treat operands as two's-complement signed.
module tt_um_tpu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  load_idx_q, load_idx_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  a_q [4];
  logic [7:0]  a_d [4];
  logic [7:0]  b_q [4];
  logic [7:0]  b_d [4];
  logic [15:0] c_q [4];
  logic [15:0] c_d [4];

  logic        load_s, read_s, clr_s;
  logic        k00_s, kl_s, v00_s, vl_s;
  logic [15:0] sel_s;
  logic        unused_s;

  assign load_s   = ena & uio_in[0];
  assign read_s   = ena & uio_in[1];
  assign clr_s    = ena & uio_in[2];
  assign unused_s = &{1'b0, uio_in[7:3]};

  // Product of one operand pair, as a 16-bit value (sums wrap modulo 2^16).
  function automatic logic [15:0] mac_product(input logic [7:0] x, input logic [7:0] y);
`ifdef TPU_SIGNED_EN
    logic signed [15:0] xs;
    logic signed [15:0] ys;
    xs = {{8{x[7]}}, x};
    ys = {{8{y[7]}}, y};
    return xs * ys;
`else
    return {8'd0, x} * {8'd0, y};
`endif
  endfunction

  // Systolic skew: cell 00 runs k=0,1 on compute cycles 0,1. The other
  // three cells are one wavefront behind and run k=0,1 on cycles 1,2.
  assign v00_s = ~cnt_q[1];
  assign k00_s = cnt_q[0];
  assign vl_s  = (cnt_q != 2'd0);
  assign kl_s  = cnt_q[1];

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; soft clear wins over load and read.
  always_comb begin
    state_d = state_q;
    if (clr_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (load_s && load_idx_q == 3'd7) state_d = S_COMPUTE; else state_d = S_IDLE;
        S_COMPUTE: if (ena && cnt_q == 2'd2)         state_d = S_DONE;    else state_d = S_COMPUTE;
        S_DONE:    if (read_s && rd_ptr_q == 3'd7)   state_d = S_IDLE;    else state_d = S_DONE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: result byte only while DONE, status bits from the state.
  always_comb begin
    sel_s   = c_q[rd_ptr_q[2:1]];
    uo_out  = 8'd0;
    uio_out = {(state_q == S_DONE), (state_q == S_COMPUTE), 6'd0};
    uio_oe  = 8'b1100_0000;
    if (state_q == S_DONE) uo_out = rd_ptr_q[0] ? sel_s[7:0] : sel_s[15:8];
    else                   uo_out = 8'd0;
  end

  // Datapath next values: operand capture, MAC accumulation, read pointer.
  always_comb begin
    load_idx_d = load_idx_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    for (int n = 0; n < 4; n++) begin
      a_d[n] = a_q[n];
      b_d[n] = b_q[n];
      c_d[n] = c_q[n];
    end
    if (clr_s) begin
      load_idx_d = 3'd0;
      rd_ptr_d   = 3'd0;
      cnt_d      = 2'd0;
      for (int n = 0; n < 4; n++) c_d[n] = 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_s) begin
            if (load_idx_q[2]) b_d[load_idx_q[1:0]] = ui_in;
            else               a_d[load_idx_q[1:0]] = ui_in;
            load_idx_d = load_idx_q + 3'd1;
            // Entering COMPUTE: start the accumulators from zero.
            if (load_idx_q == 3'd7) begin
              cnt_d = 2'd0;
              for (int n = 0; n < 4; n++) c_d[n] = 16'd0;
            end else begin
              cnt_d = cnt_q;
            end
          end else begin
            load_idx_d = load_idx_q;
          end
        end
        S_COMPUTE: begin
          if (ena) begin
            cnt_d = cnt_q + 2'd1;
            if (v00_s) c_d[0] = c_q[0] + mac_product(a_q[{1'b0, k00_s}], b_q[{k00_s, 1'b0}]);
            else       c_d[0] = c_q[0];
            if (vl_s) begin
              c_d[1] = c_q[1] + mac_product(a_q[{1'b0, kl_s}], b_q[{kl_s, 1'b1}]);
              c_d[2] = c_q[2] + mac_product(a_q[{1'b1, kl_s}], b_q[{kl_s, 1'b0}]);
              c_d[3] = c_q[3] + mac_product(a_q[{1'b1, kl_s}], b_q[{kl_s, 1'b1}]);
            end else begin
              c_d[1] = c_q[1];
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_DONE: begin
          if (read_s) rd_ptr_d = rd_ptr_q + 3'd1;
          else        rd_ptr_d = rd_ptr_q;
        end
        default: begin
          load_idx_d = 3'd0;
          rd_ptr_d   = 3'd0;
        end
      endcase
    end
  end

  // Datapath registers; reset clears operands and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_idx_q <= 3'd0;
      rd_ptr_q   <= 3'd0;
      cnt_q      <= 2'd0;
      for (int n = 0; n < 4; n++) begin
        a_q[n] <= 8'd0;
        b_q[n] <= 8'd0;
        c_q[n] <= 16'd0;
      end
    end else begin
      load_idx_q <= load_idx_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      for (int n = 0; n < 4; n++) begin
        a_q[n] <= a_d[n];
        b_q[n] <= b_d[n];
        c_q[n] <= c_d[n];
      end
    end
  end

endmodule

// File: tb/tb_tt_um_tpu.sv
// Self-checking bench for tt_um_tpu: a scoreboard queue receives the expected
// result bytes when operands are loaded, and they are compared during readout.
module tb_tt_um_tpu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  tt_um_tpu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_mul(input logic [7:0] x, input logic [7:0] y);
`ifdef TPU_SIGNED_EN
    return int'($signed(x)) * int'($signed(y));
`else
    return int'(x) * int'(y);
`endif
  endfunction

  function automatic logic [15:0] ref_elem(input logic [7:0] am [4], input logic [7:0] bm [4],
                                           input int i, input int j);
    int s;
    s = 0;
    for (int k = 0; k < 2; k++) s += ref_mul(am[i*2+k], bm[k*2+j]);
    return s[15:0];
  endfunction

  task automatic load_mats(input logic [7:0] am [4], input logic [7:0] bm [4]);
    logic [15:0] c;
    for (int n = 0; n < 8; n++) begin
      ui_in  = (n < 4) ? am[n] : bm[n-4];
      uio_in = 8'h01;
      step();
    end
    uio_in = 8'h00;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        c = ref_elem(am, bm, i, j);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
      end
  endtask

  task automatic expect_compute();
    check_eq("busy0", uio_out, 16'h0040);
    step();
    check_eq("busy1", uio_out, 16'h0040);
    step();
    check_eq("busy2", uio_out, 16'h0040);
    step();
    check_eq("done", uio_out, 16'h0080);
  endtask

  task automatic read_out(input logic [7:0] strobe);
    logic [7:0] e;
    check_eq("sb_depth", 16'(exp_q.size()), 16'd8);
    for (int n = 0; n < 8; n++) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("rd_byte", uo_out, e);
      end
      uio_in = strobe;
      step();
      uio_in = 8'h00;
    end
    check_eq("idle_status", uio_out, 16'h0000);
    check_eq("idle_out", uo_out, 16'h0000);
  endtask

  task automatic run_case(input logic [7:0] am [4], input logic [7:0] bm [4]);
    load_mats(am, bm);
    expect_compute();
    read_out(8'h02);
  endtask

  logic [7:0] ma [4];
  logic [7:0] mb [4];

  initial begin
    #12;
    check_eq("rst_uo", uo_out, 16'h0000);
    check_eq("rst_uio", uio_out, 16'h0000);
    check_eq("rst_oe", uio_oe, 16'h00C0);
    rst_n = 1'b1;
    ena   = 1'b1;
    step();

    // Read strobes in IDLE must not move the read pointer.
    uio_in = 8'h02;
    step();
    step();
    uio_in = 8'h00;

    // Basic example: bytes 00 13 00 16 00 2B 00 32.
    ma = '{8'd1, 8'd2, 8'd3, 8'd4};
    mb = '{8'd5, 8'd6, 8'd7, 8'd8};
    run_case(ma, mb);

`ifdef TPU_SIGNED_EN
    ma = '{8'h80, 8'h80, 8'h80, 8'h80};
    mb = '{8'h80, 8'h80, 8'h80, 8'h80};
    run_case(ma, mb);
    ma = '{8'hFF, 8'h00, 8'h00, 8'hFF};
    mb = '{8'd2, 8'd3, 8'd4, 8'd5};
    run_case(ma, mb);
`else
    ma = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    mb = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_case(ma, mb);
`endif

    // Random operands.
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 4; n++) begin
        ma[n] = 8'($urandom_range(0, 255));
        mb[n] = 8'($urandom_range(0, 255));
      end
      run_case(ma, mb);
    end

    // Reset during COMPUTE aborts; a fresh load then works.
    ma = '{8'd9, 8'd8, 8'd7, 8'd6};
    mb = '{8'd5, 8'd4, 8'd3, 8'd2};
    load_mats(ma, mb);
    step();
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_uio", uio_out, 16'h0000);
    check_eq("rst_mid_uo", uo_out, 16'h0000);
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    step();
    ma = '{8'd11, 8'd12, 8'd13, 8'd14};
    mb = '{8'd21, 8'd22, 8'd23, 8'd24};
    run_case(ma, mb);

    // Soft clear after five loads restarts the load index.
    for (int n = 0; n < 5; n++) begin
      ui_in  = 8'hA5;
      uio_in = 8'h01;
      step();
    end
    uio_in = 8'h04;
    step();
    uio_in = 8'h00;
    check_eq("clr_status", uio_out, 16'h0000);
    ma = '{8'd3, 8'd1, 8'd4, 8'd1};
    mb = '{8'd5, 8'd9, 8'd2, 8'd6};
    run_case(ma, mb);

    // ena=0 in IDLE: load strobes ignored.
    ena    = 1'b0;
    ui_in  = 8'h77;
    uio_in = 8'h01;
    step();
    step();
    step();
    uio_in = 8'h00;
    ena    = 1'b1;
    ma = '{8'd10, 8'd20, 8'd30, 8'd40};
    mb = '{8'd2, 8'd4, 8'd6, 8'd8};
    load_mats(ma, mb);
    expect_compute();
    // ena=0 in DONE: read strobes ignored.
    ena    = 1'b0;
    uio_in = 8'h02;
    step();
    step();
    uio_in = 8'h00;
    ena    = 1'b1;
    // Load strobes in DONE leave results unchanged.
    ui_in  = 8'h55;
    uio_in = 8'h01;
    step();
    step();
    uio_in = 8'h00;
    check_eq("done_hold", uio_out, 16'h0080);
    // Load and read together in DONE: only the read acts.
    read_out(8'h03);

    // Soft clear while DONE returns to IDLE with zeroed output.
    ma = '{8'd1, 8'd1, 8'd1, 8'd1};
    mb = '{8'd200, 8'd100, 8'd50, 8'd25};
    load_mats(ma, mb);
    expect_compute();
    uio_in = 8'h04;
    step();
    uio_in = 8'h00;
    check_eq("clr_done_uio", uio_out, 16'h0000);
    check_eq("clr_done_uo", uo_out, 16'h0000);
    exp_q.delete();
    ma = '{8'd2, 8'd0, 8'd0, 8'd2};
    run_case(ma, mb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
